mem_access_arbiter: RTL and testbench

//  Shares the single 8x256-bit Mem array between two requesters: port 0 (matrix

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_rr_arbiter.sv | 55 +++++
 rtl/mem_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the Mem access arbiter slice.
//   - MEM_ADDR_W / MEM_DATA_W : default row address / row data widths
//   - arb_state_t             : arbiter sequencing states
//   - MEM_READ / MEM_WRITE    : encoding of the memRW / pXRW signals
//   - PORT_EXE / PORT_LD      : requester identifiers (owner, lastGrant)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 3;
    localparam int unsigned MEM_DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } arb_state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam logic PORT_EXE = 1'b0;  // matrix execution engine
    localparam logic PORT_LD  = 1'b1;  // host / operand loader

endpackage

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
//   Two-way grant logic for the Mem access arbiter. Purely combinational;
//   the caller qualifies the grants with its own idle condition.
//
//   Build option: MEM_ARB_FIXED_PRIO_EN
//     defined   : fixed priority, port 0 wins every tie, last_grant ignored
//     undefined : round-robin, a tie goes to the port that did not win last
//
//   Ports
//     valid0     in   port 0 request valid
//     valid1     in   port 1 request valid
//     last_grant in   port that won the previous arbitration
//     grant0     out  port 0 wins (never together with grant1)
//     grant1     out  port 1 wins
// ---------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

`ifdef MEM_ARB_FIXED_PRIO_EN

    // History is irrelevant with fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant0 = valid0;
        grant1 = valid1 && !valid0;
    end

`else

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (valid0 && valid1) begin
            // Tie: hand the grant to whichever port did not win last time.
            grant0 = (last_grant != PORT_EXE);
            grant1 = (last_grant == PORT_EXE);
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//   Shares the single 8 x 256-bit Mem array between two requesters:
//   port 0 (matrix execution engine) and port 1 (host/operand loader).
//   One request is accepted in IDLE, its fields are latched onto the Mem
//   inputs, and a fixed sequence IDLE -> SETUP -> STROBE -> DONE -> IDLE
//   produces exactly one clean memDo pulse per operation. Read data is
//   captured from memBus when the strobe ends and returned with a one-cycle
//   done pulse to the owning port.
//
//   Timing (E0 = accept edge):
//     E0: fields latched, state SETUP (memDo low, Mem inputs settle)
//     E1: memDo rises (STROBE), Mem performs the operation
//     E2: memDo falls, owner's done pulses, read data registered (DONE)
//     E3: back to IDLE
//
//   Build option: MEM_ARB_FIXED_PRIO_EN (see mem_rr_arbiter) selects fixed
//   priority instead of round-robin tie breaking.
//
//   Parameters
//     ADDR_W  Mem row address width
//     DATA_W  Mem row width
//
//   Ports
//     clk, reset           clock; asynchronous active-high reset
//     p0Valid/p1Valid      request valid
//     p0Ready/p1Ready      request accepted this cycle (combinational, IDLE only)
//     p0RW/p1RW            1 = read, 0 = write
//     p0Addr/p1Addr        row address
//     p0Wdata/p1Wdata      write data
//     p0Done/p1Done        one-cycle completion pulse
//     p0Rdata/p1Rdata      read data, valid with done on reads
//     memAddr/memRW/memWrite  latched request to Mem (held in IDLE)
//     memDo                registered strobe; Mem acts on its rising edge
//     memBus               read data from Mem
//     busy                 high whenever the sequencer is not in IDLE
// ---------------------------------------------------------------------------
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0Valid,
    output logic              p0Ready,
    input  logic              p0RW,
    input  logic [ADDR_W-1:0] p0Addr,
    input  logic [DATA_W-1:0] p0Wdata,
    output logic              p0Done,
    output logic [DATA_W-1:0] p0Rdata,

    input  logic              p1Valid,
    output logic              p1Ready,
    input  logic              p1RW,
    input  logic [ADDR_W-1:0] p1Addr,
    input  logic [DATA_W-1:0] p1Wdata,
    output logic              p1Done,
    output logic [DATA_W-1:0] p1Rdata,

    output logic [ADDR_W-1:0] memAddr,
    output logic              memRW,
    output logic [DATA_W-1:0] memWrite,
    output logic              memDo,
    input  logic [DATA_W-1:0] memBus,

    output logic              busy
);

    arb_state_t state;
    logic       owner;       // port that owns the operation in flight
    logic       last_grant;  // port that won the most recent arbitration
    logic       grant0;
    logic       grant1;

    mem_rr_arbiter u_arb (
        .valid0     (p0Valid),
        .valid1     (p1Valid),
        .last_grant (last_grant),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    // Ready is only offered while idle, so at most one request is ever
    // accepted per operation and the two readies are mutually exclusive.
    assign p0Ready = (state == IDLE) && grant0;
    assign p1Ready = (state == IDLE) && grant1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= PORT_EXE;
            last_grant <= PORT_LD;      // port 0 wins the first tie
            memAddr    <= '0;
            memRW      <= MEM_READ;     // a read is harmless if strobed
            memWrite   <= '0;
            memDo      <= 1'b0;
            p0Done     <= 1'b0;
            p1Done     <= 1'b0;
            p0Rdata    <= '0;
            p1Rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p1Ready) begin
                        memAddr    <= p1Addr;
                        memRW      <= p1RW;
                        memWrite   <= p1Wdata;
                        owner      <= PORT_LD;
                        last_grant <= PORT_LD;
                        state      <= SETUP;
                    end else if (p0Ready) begin
                        memAddr    <= p0Addr;
                        memRW      <= p0RW;
                        memWrite   <= p0Wdata;
                        owner      <= PORT_EXE;
                        last_grant <= PORT_EXE;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    // Mem inputs have been stable for a full cycle; raise the strobe.
                    memDo <= 1'b1;
                    state <= STROBE;
                end

                STROBE: begin
                    memDo <= 1'b0;
                    if (owner == PORT_EXE) begin
                        p0Done <= 1'b1;
                        if (memRW == MEM_READ) begin
                            p0Rdata <= memBus;
                        end
                    end else begin
                        p1Done <= 1'b1;
                        if (memRW == MEM_READ) begin
                            p1Rdata <= memBus;
                        end
                    end
                    state <= DONE;
                end

                DONE: begin
                    p0Done <= 1'b0;
                    p1Done <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_access_arbiter
//   Bench for mem_access_arbiter with a behavioural Mem model. A reference
//   model tracks which port should win, how long the arbiter stays busy, and
//   the contents of Mem; expected completions go into a scoreboard queue that
//   the monitor drains whenever a done pulse appears.
// ---------------------------------------------------------------------------
module tb_mem_access_arbiter;

    localparam int AW = 3;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0Valid, p0Ready, p0RW, p0Done;
    logic [AW-1:0] p0Addr;
    logic [DW-1:0] p0Wdata, p0Rdata;
    logic          p1Valid, p1Ready, p1RW, p1Done;
    logic [AW-1:0] p1Addr;
    logic [DW-1:0] p1Wdata, p1Rdata;
    logic [AW-1:0] memAddr;
    logic          memRW, memDo, busy;
    logic [DW-1:0] memWrite, memBus;

    always #5 clk = ~clk;

    mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .p0Valid(p0Valid), .p0Ready(p0Ready), .p0RW(p0RW), .p0Addr(p0Addr),
        .p0Wdata(p0Wdata), .p0Done(p0Done), .p0Rdata(p0Rdata),
        .p1Valid(p1Valid), .p1Ready(p1Ready), .p1RW(p1RW), .p1Addr(p1Addr),
        .p1Wdata(p1Wdata), .p1Done(p1Done), .p1Rdata(p1Rdata),
        .memAddr(memAddr), .memRW(memRW), .memWrite(memWrite), .memDo(memDo),
        .memBus(memBus), .busy(busy)
    );

    function automatic logic [DW-1:0] init_row(input int i);
        return {8{32'(32'hC0DE_0000 + i)}};
    endfunction

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- behavioural Mem ----------------
    logic [DW-1:0] mem [8];
    int unsigned   do_rises = 0;
    assign memBus = mem[memAddr];

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = init_row(i);
        forever begin
            @(posedge memDo);
            do_rises++;
            if (memRW == 1'b0) mem[memAddr] = memWrite;
        end
    end

    // ---------------- reference model + monitor ----------------
    typedef struct {
        logic          port;
        logic          rd;
        logic [DW-1:0] data;
        int unsigned   cyc;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            timeouts = 0;
    bit            stim_done = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Returns winning port (0/1) or -1 when nobody requests.
    function automatic int winner(input logic v0, input logic v1, input int last);
        if (!v0 && !v1) return -1;
        if (v0 && v1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            return (last >= 0) ? 0 : 0;
`else
            return (last == 1) ? 0 : 1;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    initial begin
        logic [DW-1:0] ref_mem [8];
        logic [DW-1:0] model_rdata [2];
        int            exp_last;
        int            busy_left;   // cycles of busy remaining after the accept edge
        int            win;
        int            op_port;
        logic          op_rd;
        logic [AW-1:0] op_addr;
        logic [DW-1:0] op_data;
        int unsigned   cyc;
        exp_t          e;
        logic [DW-1:0] exp_rd;

        for (int i = 0; i < 8; i++) ref_mem[i] = init_row(i);
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        exp_last  = 1;
        busy_left = 0;
        win       = -1;
        op_port   = 0;
        op_rd     = 1'b1;
        op_addr   = '0;
        op_data   = '0;
        cyc       = 0;

        forever begin
            @(negedge clk);
            if (reset) begin
                // Anything not yet strobed is abandoned; strobed writes stay in ref_mem.
                busy_left = 0;
                exp_last  = 1;
                win       = -1;
                sb.delete();
                model_rdata[0] = '0;
                model_rdata[1] = '0;
                chk("rst_memAddr", DW'(memAddr), '0);
                chk("rst_memRW", DW'(memRW), 1);
                chk("rst_memWrite", memWrite, '0);
                chk("rst_memDo", DW'(memDo), '0);
                chk("rst_done", DW'({p1Done, p0Done}), '0);
                chk("rst_p0Rdata", p0Rdata, '0);
                chk("rst_p1Rdata", p1Rdata, '0);
                chk("rst_busy", DW'(busy), '0);
            end else begin
                win = (busy_left == 0) ? winner(p0Valid, p1Valid, exp_last) : -1;
                chk("p0Ready", DW'(p0Ready), DW'(win == 0));
                chk("p1Ready", DW'(p1Ready), DW'(win == 1));
                chk("busy", DW'(busy), DW'(busy_left != 0));
                chk("memDo", DW'(memDo), DW'(busy_left == 2));
                if (busy_left == 3 || busy_left == 2) begin
                    chk("memAddr", DW'(memAddr), DW'(op_addr));
                    chk("memRW", DW'(memRW), DW'(op_rd));
                    if (!op_rd) chk("memWrite", memWrite, op_data);
                end
                if (p0Done || p1Done) begin
                    if (sb.size() == 0) begin
                        chk("done_unexpected", DW'({p1Done, p0Done}), '0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_port", DW'({p1Done, p0Done}), e.port ? DW'(2) : DW'(1));
                        chk("done_cycle", DW'(cyc), DW'(e.cyc));
                        exp_rd = e.rd ? e.data : model_rdata[e.port];
                        model_rdata[e.port] = exp_rd;
                        chk(e.port ? "p1Rdata" : "p0Rdata", e.port ? p1Rdata : p0Rdata, exp_rd);
                    end
                end
            end

            if (stim_done) break;

            @(posedge clk);
            cyc++;
            if (!reset) begin
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 2) begin
                        // Strobe edge: the operation takes effect in Mem now.
                        e.port = op_port[0];
                        e.rd   = op_rd;
                        e.data = op_rd ? ref_mem[op_addr] : op_data;
                        e.cyc  = cyc + 1;
                        if (!op_rd) ref_mem[op_addr] = op_data;
                        sb.push_back(e);
                    end
                end else if (win >= 0) begin
                    op_port   = win;
                    op_rd     = (win == 1) ? p1RW : p0RW;
                    op_addr   = (win == 1) ? p1Addr : p0Addr;
                    op_data   = (win == 1) ? p1Wdata : p0Wdata;
                    exp_last  = win;
                    busy_left = 3;
                end
            end
        end

        chk("sb_empty", DW'(sb.size()), '0);
        chk("stim_timeouts", DW'(timeouts), '0);
        for (int i = 0; i < 8; i++) chk("mem_row", mem[i], ref_mem[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    task automatic set_port(input int port, input logic v, input logic rw,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            p0Valid = v; p0RW = rw; p0Addr = a; p0Wdata = d;
        end else begin
            p1Valid = v; p1RW = rw; p1Addr = a; p1Wdata = d;
        end
    endtask

    // Presents one request and returns one cycle after it was accepted (SETUP).
    task automatic do_op(input int port, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bit got;
        got = 0;
        set_port(port, 1'b1, rw, a, d);
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0Ready : p1Ready) got = 1;
            @(posedge clk);
            #1;
        end
        if (!got) timeouts++;
        if (port == 0) p0Valid = 1'b0; else p1Valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
    endtask

    initial begin
        bit a0, a1;
        reset = 1'b1;
        set_port(0, 1'b0, 1'b1, '0, '0);
        set_port(1, 1'b0, 1'b1, '0, '0);
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(1);

        // Write from loader, then read back from engine.
        do_op(1, 1'b0, 3'd3, {32{8'hA5}});
        do_op(0, 1'b1, 3'd3, '0);
        idle_cycles(4);

        // Both ports hold read requests after reset: grants alternate.
        pulse_reset();
        set_port(0, 1'b1, 1'b1, 3'd1, '0);
        set_port(1, 1'b1, 1'b1, 3'd2, '0);
        idle_cycles(17);
        p0Valid = 1'b0;
        p1Valid = 1'b0;
        idle_cycles(4);

        // Back-to-back write/read on the same row.
        do_op(0, 1'b0, 3'd7, 256'h1);
        do_op(0, 1'b1, 3'd7, '0);
        idle_cycles(4);

        // Reset during SETUP of a write: the write must never reach Mem.
        do_op(0, 1'b0, 3'd5, {8{32'hDEAD_BEEF}});
        #1 reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(2);

        // Valid pulsed for one cycle while busy, then dropped.
        do_op(0, 1'b1, 3'd4, '0);
        set_port(1, 1'b1, 1'b0, 3'd6, {8{32'h0BAD_F00D}});
        idle_cycles(1);
        p1Valid = 1'b0;
        idle_cycles(4);

        // Read then write: write completion leaves read data untouched.
        do_op(0, 1'b1, 3'd2, '0);
        do_op(0, 1'b0, 3'd0, {4{64'h1234_5678_9ABC_DEF0}});
        idle_cycles(4);

        // Randomized traffic; fields only change when valid is low or accepted.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            a0 = p0Valid && p0Ready;
            a1 = p1Valid && p1Ready;
            @(posedge clk);
            #1;
            if (p0Valid && !a0) begin
                if ($urandom_range(0, 7) == 0) p0Valid = 1'b0;
            end else begin
                set_port(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         AW'($urandom_range(0, 7)), rand_row());
            end
            if (p1Valid && !a1) begin
                if ($urandom_range(0, 7) == 0) p1Valid = 1'b0;
            end else begin
                set_port(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         AW'($urandom_range(0, 7)), rand_row());
            end
        end
        p0Valid = 1'b0;
        p1Valid = 1'b0;
        idle_cycles(6);
        stim_done = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
